// File: rtl/sgd_loss_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sgd_loss_pop_scheduler
// Brief    : Lock-step pop sequencer for the per-engine dot-product FIFOs and
//            the shared b FIFO that feed the loss stage. Pops only when every
//            source holds a sample and downstream has credit, enforces a
//            minimum pop-to-pop spacing, counts samples per run and flags
//            engine skew as a sticky diagnostic.
// Revision : 1.0 - initial release
// ============================================================================
module sgd_loss_pop_scheduler #(
    parameter int ENGINE_NUM   = 8,
    parameter int POP_GAP      = 8,
    parameter int CREDIT_MAX   = 16,
    parameter int SKEW_LIMIT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             num_samples,
    input  logic [SKEW_LIMIT_W-1:0] skew_limit,
    input  logic [ENGINE_NUM-1:0]   fifo_a_empty,
    input  logic                    fifo_b_empty,
    input  logic                    credit_return,
    output logic [ENGINE_NUM-1:0]   pop_a,
    output logic                    pop_b,
    output logic                    busy,
    output logic                    done,
    output logic                    skew_err,
    output logic [ENGINE_NUM-1:0]   skew_mask,
    output logic [31:0]             samples_popped
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WAIT = 3'd1;
    localparam logic [2:0] c_ST_POP  = 3'd2;
    localparam logic [2:0] c_ST_GAP  = 3'd3;
    localparam logic [2:0] c_ST_FIN  = 3'd4;

    localparam int c_CRED_W = $clog2(CREDIT_MAX + 1);
    localparam logic [c_CRED_W-1:0] c_CRED_MAX = c_CRED_W'(CREDIT_MAX);

    // POP cycle + GAP cycles + one WAIT evaluation cycle span POP_GAP cycles,
    // so GAP itself lasts POP_GAP-2 cycles (counter loaded with POP_GAP-3).
    localparam logic [7:0] c_GAP_LOAD = (POP_GAP > 2) ? 8'(POP_GAP - 3) : 8'd0;
    localparam bit c_SKIP_GAP = (POP_GAP <= 2);

    logic [2:0]              r_state;
    logic [31:0]             r_num_samples;
    logic [31:0]             r_samples_popped;
    logic [7:0]              r_gap_cnt;
    logic [c_CRED_W-1:0]     r_credits;
    logic [SKEW_LIMIT_W-1:0] r_skew_cnt;
    logic                    r_pop;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_skew_err;
    logic [ENGINE_NUM-1:0]   r_skew_mask;

    logic                    w_a_all_full;
    logic                    w_a_all_empty;
    logic                    w_partial;
    logic                    w_ready;
    logic                    w_last;
    logic                    w_in_wait;
    logic                    w_skew_inc;
    logic [SKEW_LIMIT_W-1:0] w_skew_next;
    logic                    w_skew_hit;
    logic                    w_cred_dec;

    assign w_a_all_full  = (fifo_a_empty == '0);
    assign w_a_all_empty = &fifo_a_empty;
    assign w_partial     = !w_a_all_full && !w_a_all_empty;
    assign w_ready       = w_a_all_full && !fifo_b_empty && (r_credits != '0);
    assign w_last        = ((r_samples_popped + 32'd1) == r_num_samples);
    assign w_in_wait     = (r_state == c_ST_WAIT);
    assign w_skew_inc    = w_in_wait && w_partial;
    assign w_skew_next   = (&r_skew_cnt) ? r_skew_cnt : (r_skew_cnt + 1'b1);
    // Capture only the first crossing so the mask shows the original culprits.
    assign w_skew_hit    = w_skew_inc && (skew_limit != '0) &&
                           (w_skew_next == skew_limit) && !r_skew_err;
    assign w_cred_dec    = (r_state == c_ST_POP);

    // Downstream credit tracking; survives runs because results drain after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= c_CRED_MAX;
        end else if (w_cred_dec && !credit_return) begin
            r_credits <= r_credits - 1'b1;
        end else if (!w_cred_dec && credit_return && (r_credits != c_CRED_MAX)) begin
            r_credits <= r_credits + 1'b1;
        end
    end

    // Skew timer: counts consecutive WAIT cycles with a partial engine set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skew_cnt <= '0;
        end else if (w_skew_inc) begin
            r_skew_cnt <= w_skew_next;
        end else begin
            r_skew_cnt <= '0;
        end
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_num_samples    <= '0;
            r_samples_popped <= '0;
            r_gap_cnt        <= '0;
            r_pop            <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_skew_err       <= 1'b0;
            r_skew_mask      <= '0;
        end else begin
            r_pop  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_num_samples    <= num_samples;
                        r_samples_popped <= '0;
                        r_skew_err       <= 1'b0;
                        r_skew_mask      <= '0;
                        r_busy           <= 1'b1;
                        if (num_samples == 32'd0) begin
                            r_state <= c_ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_skew_hit) begin
                        r_skew_err  <= 1'b1;
                        r_skew_mask <= fifo_a_empty;
                    end
                    if (w_ready) begin
                        r_state <= c_ST_POP;
                        r_pop   <= 1'b1;
                    end
                end
                c_ST_POP: begin
                    r_samples_popped <= r_samples_popped + 32'd1;
                    if (w_last) begin
                        r_state <= c_ST_FIN;
                        r_done  <= 1'b1;
                    end else if (c_SKIP_GAP) begin
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_state   <= c_ST_GAP;
                        r_gap_cnt <= c_GAP_LOAD;
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                c_ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pop_a          = {ENGINE_NUM{r_pop}};
    assign pop_b          = r_pop;
    assign busy           = r_busy;
    assign done           = r_done;
    assign skew_err       = r_skew_err;
    assign skew_mask      = r_skew_mask;
    assign samples_popped = r_samples_popped;

endmodule
`default_nettype wire

// File: tb/tb_sgd_loss_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgd_loss_pop_scheduler
// Brief    : Scoreboard bench for sgd_loss_pop_scheduler. Stimulus pushes the
//            expected pop/done events (cycle, kind, samples_popped); a monitor
//            pops and compares each time the DUT presents one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgd_loss_pop_scheduler;

    localparam int c_EN = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [31:0]     num_samples;
    logic [15:0]     skew_limit;
    logic [c_EN-1:0] fifo_a_empty;
    logic            fifo_b_empty;
    logic            credit_return;
    logic [c_EN-1:0] pop_a;
    logic            pop_b;
    logic            busy;
    logic            done;
    logic            skew_err;
    logic [c_EN-1:0] skew_mask;
    logic [31:0]     samples_popped;

    sgd_loss_pop_scheduler #(
        .ENGINE_NUM  (c_EN),
        .POP_GAP     (8),
        .CREDIT_MAX  (16),
        .SKEW_LIMIT_W(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_samples   (num_samples),
        .skew_limit    (skew_limit),
        .fifo_a_empty  (fifo_a_empty),
        .fifo_b_empty  (fifo_b_empty),
        .credit_return (credit_return),
        .pop_a         (pop_a),
        .pop_b         (pop_b),
        .busy          (busy),
        .done          (done),
        .skew_err      (skew_err),
        .skew_mask     (skew_mask),
        .samples_popped(samples_popped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_pop;
        int sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input bit ok, input string act, input string req);
        n_total++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, want %s", name, act, req);
        end
    endtask

    // Monitor: every pop or done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (pop_a != '0 || pop_b || done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1'b0,
                      $sformatf("cyc=%0d pop_a=%h pop_b=%b done=%b sp=%0d", cyc, pop_a, pop_b, done, samples_popped),
                      "no event");
            end else begin
                exp_t e;
                bit   ok;
                e  = exp_q.pop_front();
                ok = (e.cyc == cyc) && (samples_popped == 32'(e.sp)) &&
                     (e.is_pop ? (pop_a == 8'hFF && pop_b && !done)
                               : (pop_a == 8'h00 && !pop_b && done));
                check("event", ok,
                      $sformatf("cyc=%0d pop_a=%h pop_b=%b done=%b sp=%0d", cyc, pop_a, pop_b, done, samples_popped),
                      $sformatf("cyc=%0d %s sp=%0d", e.cyc, e.is_pop ? "pop" : "done", e.sp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input bit p, input int sp);
        exp_t e;
        e.cyc    = c;
        e.is_pop = p;
        e.sp     = sp;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
        exp_q.delete();
    endtask

    task automatic do_start(input logic [31:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic give_credits(input int n);
        credit_return = 1'b1;
        repeat (n) tick();
        credit_return = 1'b0;
    endtask

    function automatic bit outs_zero();
        return (pop_a == '0) && !pop_b && !busy && !done && !skew_err &&
               (skew_mask == '0) && (samples_popped == '0);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int c;
        int d;
        rst           = 1'b1;
        start         = 1'b0;
        num_samples   = '0;
        skew_limit    = '0;
        fifo_a_empty  = '1;
        fifo_b_empty  = 1'b1;
        credit_return = 1'b0;
        tick();
        tick();
        check("reset_state", outs_zero(), $sformatf("busy=%b sp=%0d", busy, samples_popped), "all zero");
        rst = 1'b0;
        tick();

        // T1: three samples, pops spaced by POP_GAP, late start ignored
        fifo_a_empty = '0;
        fifo_b_empty = 1'b0;
        s = cyc;
        push(s + 2, 1, 0);
        push(s + 10, 1, 1);
        push(s + 18, 1, 2);
        push(s + 19, 0, 3);
        do_start(3);
        check("t1_busy", busy == 1'b1, $sformatf("%b", busy), "1");
        run_to(s + 5);
        do_start(99);
        drain("t1_events", 40);
        run_to(s + 20);
        check("t1_after", !busy && samples_popped == 32'd3,
              $sformatf("busy=%b sp=%0d", busy, samples_popped), "busy=0 sp=3");

        // Credits 13 -> saturate at 16 with 5 returns
        give_credits(5);

        // T2: credit exhaustion after 16 pops, single return, return+pop same cycle
        s = cyc;
        for (int k = 0; k < 16; k++) push(s + 2 + 8 * k, 1, k);
        do_start(20);
        run_to(s + 150);
        check("t2_16pops", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
        check("t2_stall", busy && samples_popped == 32'd16,
              $sformatf("busy=%b sp=%0d", busy, samples_popped), "busy=1 sp=16");
        c = cyc;
        push(c + 2, 1, 16);
        push(c + 10, 1, 17);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        tick();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        drain("t2_return", 20);
        run_to(c + 30);
        check("t2_stall2", busy && samples_popped == 32'd18,
              $sformatf("busy=%b sp=%0d", busy, samples_popped), "busy=1 sp=18");
        d = cyc;
        push(d + 2, 1, 18);
        push(d + 10, 1, 19);
        push(d + 11, 0, 20);
        give_credits(2);
        drain("t2_finish", 30);

        do_reset();

        // T5: reset during GAP aborts the run; credits return to 16
        s = cyc;
        push(s + 2, 1, 0);
        push(s + 10, 1, 1);
        do_start(10);
        run_to(s + 13);
        rst = 1'b1;
        #1;
        check("t5_async_reset", outs_zero(),
              $sformatf("pop_a=%h busy=%b done=%b sp=%0d", pop_a, busy, done, samples_popped), "all zero");
        check("t5_pops_before", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        s = cyc;
        for (int k = 0; k < 16; k++) push(s + 2 + 8 * k, 1, k);
        push(s + 2 + 8 * 15 + 1, 0, 16);
        do_start(16);
        drain("t5_rerun", 200);

        give_credits(6);

        // T3: engine 5 empty -> skew flagged after 10 WAIT cycles, then resumes
        fifo_a_empty = 8'h20;
        fifo_b_empty = 1'b0;
        skew_limit   = 16'd10;
        s = cyc;
        do_start(2);
        run_to(s + 10);
        check("t3_before_limit", skew_err == 1'b0, $sformatf("%b", skew_err), "0");
        run_to(s + 11);
        check("t3_at_limit", skew_err && skew_mask == 8'h20,
              $sformatf("err=%b mask=%h", skew_err, skew_mask), "err=1 mask=20");
        run_to(s + 15);
        c = cyc;
        push(c + 1, 1, 0);
        push(c + 9, 1, 1);
        push(c + 10, 0, 2);
        fifo_a_empty = 8'h00;
        drain("t3_resume", 30);
        check("t3_sticky", skew_err && skew_mask == 8'h20,
              $sformatf("err=%b mask=%h", skew_err, skew_mask), "err=1 mask=20");

        // T4: zero-sample run -> done only, start clears skew flag
        s = cyc;
        push(s + 1, 0, 0);
        do_start(0);
        check("t4_start_clears", !skew_err && skew_mask == '0 && busy,
              $sformatf("err=%b mask=%h busy=%b", skew_err, skew_mask, busy), "err=0 mask=00 busy=1");
        drain("t4_done", 5);
        run_to(s + 2);
        check("t4_idle", busy == 1'b0, $sformatf("%b", busy), "0");

        // T6: b FIFO empty blocks pops without skew; b ready -> pop next cycle
        fifo_a_empty = 8'h00;
        fifo_b_empty = 1'b1;
        skew_limit   = 16'd3;
        s = cyc;
        do_start(1);
        run_to(s + 20);
        check("t6_blocked", busy && !skew_err && samples_popped == 32'd0,
              $sformatf("busy=%b err=%b sp=%0d", busy, skew_err, samples_popped), "busy=1 err=0 sp=0");
        c = cyc;
        push(c + 1, 1, 0);
        push(c + 2, 0, 1);
        fifo_b_empty = 1'b0;
        drain("t6_b_ready", 10);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
